// File: rtl/clint_timer.sv
// Core-local interruptor: 64-bit mtime/mtimecmp and msip behind a valid/ready slave port,
// driving the machine timer (IRQ7) and machine software (IRQ3) interrupt lines.
module clint_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid,
    output logic        ready,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        IRQ3,
    output logic        IRQ7
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    localparam logic [13:0] OFF_MSIP     = 14'h0000;
    localparam logic [13:0] OFF_MTCMP_LO = 14'h1000;
    localparam logic [13:0] OFF_MTCMP_HI = 14'h1001;
    localparam logic [13:0] OFF_MTIME_LO = 14'h2FFE;
    localparam logic [13:0] OFF_MTIME_HI = 14'h2FFF;

    logic          ready_q,   ready_d;
    logic [31:0]   rdata_q,   rdata_d;
    logic          msip_q,    msip_d;
    logic [31:0]   mtimeLo_q, mtimeLo_d;
    logic [31:0]   mtimeHi_q, mtimeHi_d;
    logic [31:0]   cmpLo_q,   cmpLo_d;
    logic [31:0]   cmpHi_q,   cmpHi_d;
    logic [PW-1:0] presc_q,   presc_d;
    logic          irq7_q,    irq7_d;

    logic        inWindow, accept, isWrite, tick;
    logic        selMsip, selCmpLo, selCmpHi, selTimeLo, selTimeHi;
    logic [31:0] readMux;

    function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal,
                                               input logic [31:0] newVal,
                                               input logic [3:0]  be);
        logic [31:0] res;
        res = oldVal;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[b*8 +: 8] = newVal[b*8 +: 8];
        end
        return res;
    endfunction

    // Byte offset bits [1:0] are don't-care in the word decode.
    assign selMsip   = (addr[15:0] ==? {OFF_MSIP,     2'b??});
    assign selCmpLo  = (addr[15:0] ==? {OFF_MTCMP_LO, 2'b??});
    assign selCmpHi  = (addr[15:0] ==? {OFF_MTCMP_HI, 2'b??});
    assign selTimeLo = (addr[15:0] ==? {OFF_MTIME_LO, 2'b??});
    assign selTimeHi = (addr[15:0] ==? {OFF_MTIME_HI, 2'b??});

    assign inWindow = (addr[31:16] == BASE_ADDR[31:16]);
    assign accept   = valid && !ready_q && inWindow;
    assign isWrite  = accept && (wstrb != 4'b0000);
    assign tick     = (presc_q == PRESC_MAX);

    always_comb begin
        readMux   = 32'h0;
        presc_d   = tick ? '0 : presc_q + 1'b1;
        ready_d   = accept;
        rdata_d   = rdata_q;
        msip_d    = msip_q;
        cmpLo_d   = cmpLo_q;
        cmpHi_d   = cmpHi_q;
        mtimeLo_d = mtimeLo_q;
        mtimeHi_d = mtimeHi_q;

        if (selMsip)   readMux = {31'h0, msip_q};
        if (selCmpLo)  readMux = cmpLo_q;
        if (selCmpHi)  readMux = cmpHi_q;
        if (selTimeLo) readMux = mtimeLo_q;
        if (selTimeHi) readMux = mtimeHi_q;
        if (accept)    rdata_d = readMux;

        // A bus write to a half overrides that half's tick; carry only leaves an unwritten low word.
        if (isWrite && selTimeLo) begin
            mtimeLo_d = mergeBytes(mtimeLo_q, wdata, wstrb);
        end else if (tick) begin
            mtimeLo_d = mtimeLo_q + 32'h1;
        end
        if (isWrite && selTimeHi) begin
            mtimeHi_d = mergeBytes(mtimeHi_q, wdata, wstrb);
        end else if (tick && !(isWrite && selTimeLo) && (&mtimeLo_q)) begin
            mtimeHi_d = mtimeHi_q + 32'h1;
        end

        if (isWrite && selCmpLo) cmpLo_d = mergeBytes(cmpLo_q, wdata, wstrb);
        if (isWrite && selCmpHi) cmpHi_d = mergeBytes(cmpHi_q, wdata, wstrb);
        if (isWrite && selMsip && wstrb[0]) msip_d = wdata[0];

        irq7_d = ({mtimeHi_q, mtimeLo_q} >= {cmpHi_q, cmpLo_q});
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready_q   <= 1'b0;
            rdata_q   <= 32'h0;
            msip_q    <= 1'b0;
            mtimeLo_q <= 32'h0;
            mtimeHi_q <= 32'h0;
            cmpLo_q   <= 32'hFFFF_FFFF;
            cmpHi_q   <= 32'hFFFF_FFFF;
            presc_q   <= '0;
            irq7_q    <= 1'b0;
        end else begin
            ready_q   <= ready_d;
            rdata_q   <= rdata_d;
            msip_q    <= msip_d;
            mtimeLo_q <= mtimeLo_d;
            mtimeHi_q <= mtimeHi_d;
            cmpLo_q   <= cmpLo_d;
            cmpHi_q   <= cmpHi_d;
            presc_q   <= presc_d;
            irq7_q    <= irq7_d;
        end
    end

    assign ready = ready_q;
    assign rdata = rdata_q;
    assign IRQ3  = msip_q;
    assign IRQ7  = irq7_q;

endmodule

// File: tb/tb_clint_timer.sv
// Bench for clint_timer: one instance ticking every clock (base 0x0200_0000) and one
// with TICK_DIV=4 (base 0x0300_0000) share the request bus.
module tb_clint_timer;

    logic        clk = 1'b0;
    logic        resetn;
    logic        valid;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        readyA, readyB;
    logic [31:0] rdataA, rdataB;
    logic        irq3A, irq3B, irq7A, irq7B;

    int checks = 0;
    int errors = 0;
    logic [31:0] expQ[$];

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] exp;
        logic        expIrq3;
    } vec_t;

    vec_t vecs[20];

    clint_timer #(.BASE_ADDR(32'h0200_0000), .TICK_DIV(1)) dutA (
        .clk(clk), .resetn(resetn), .valid(valid), .ready(readyA), .wstrb(wstrb),
        .addr(addr), .wdata(wdata), .rdata(rdataA), .IRQ3(irq3A), .IRQ7(irq7A)
    );

    clint_timer #(.BASE_ADDR(32'h0300_0000), .TICK_DIV(4)) dutB (
        .clk(clk), .resetn(resetn), .valid(valid), .ready(readyB), .wstrb(wstrb),
        .addr(addr), .wdata(wdata), .rdata(rdataB), .IRQ3(irq3B), .IRQ7(irq7B)
    );

    always #5 clk = ~clk;

    // Hard stop so a wedged bench still ends with a visible failure.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic curReady(input logic [31:0] a);
        return (a[31:24] == 8'h03) ? readyB : readyA;
    endfunction

    function automatic logic [31:0] curRdata(input logic [31:0] a);
        return (a[31:24] == 8'h03) ? rdataB : rdataA;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkRange(input string name, input logic [31:0] act,
                              input logic [31:0] lo, input logic [31:0] hi);
        checks++;
        if ((act < lo) || (act > hi)) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Entered and left on a falling edge; one full request/ack/idle cycle.
    task automatic applyStimulus(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                                 input logic [31:0] exp, input bit chk, output logic [31:0] rd);
        bit acked;
        logic [31:0] want;
        addr  = a;
        wstrb = s;
        wdata = d;
        valid = 1'b1;
        if (chk && s == 4'b0000) expQ.push_back(exp);
        acked = 1'b0;
        for (int i = 0; i < 8 && !acked; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (curReady(a)) acked = 1'b1;
        end
        checkOutput($sformatf("ack@%h", a), {31'h0, acked}, 32'h1);
        rd = curRdata(a);
        if (chk && s == 4'b0000) begin
            want = expQ.pop_front();
            if (acked) checkOutput($sformatf("rdata@%h", a), rd, want);
        end
        valid = 1'b0;
        wstrb = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        checkOutput($sformatf("ready_pulse@%h", a), {31'h0, curReady(a)}, 32'h0);
    endtask

    initial begin
        logic [31:0] rd;
        int first;
        int seen;

        vecs[0]  = '{32'h0200_4000, 4'h0, 32'h0,          32'hFFFF_FFFF, 1'b0};
        vecs[1]  = '{32'h0200_4004, 4'h0, 32'h0,          32'hFFFF_FFFF, 1'b0};
        vecs[2]  = '{32'h0200_0000, 4'h0, 32'h0,          32'h0,         1'b0};
        vecs[3]  = '{32'h0200_4000, 4'h5, 32'hAABB_CCDD,  32'h0,         1'b0};
        vecs[4]  = '{32'h0200_4000, 4'h0, 32'h0,          32'hFFBB_FFDD, 1'b0};
        vecs[5]  = '{32'h0200_1000, 4'h0, 32'h0,          32'h0,         1'b0};
        vecs[6]  = '{32'h0200_1000, 4'hF, 32'h1234_5678,  32'h0,         1'b0};
        vecs[7]  = '{32'h0200_1000, 4'h0, 32'h0,          32'h0,         1'b0};
        vecs[8]  = '{32'h0200_0000, 4'hF, 32'hFFFF_FFFF,  32'h0,         1'b1};
        vecs[9]  = '{32'h0200_0000, 4'h0, 32'h0,          32'h1,         1'b1};
        vecs[10] = '{32'h0200_0000, 4'h2, 32'h0,          32'h0,         1'b1};
        vecs[11] = '{32'h0200_0000, 4'h0, 32'h0,          32'h1,         1'b1};
        vecs[12] = '{32'h0200_0000, 4'h1, 32'h0,          32'h0,         1'b0};
        vecs[13] = '{32'h0200_0000, 4'h0, 32'h0,          32'h0,         1'b0};
        vecs[14] = '{32'h0200_4004, 4'hC, 32'h1234_5678,  32'h0,         1'b0};
        vecs[15] = '{32'h0200_4004, 4'h0, 32'h0,          32'h1234_FFFF, 1'b0};
        vecs[16] = '{32'h0200_4000, 4'hF, 32'hFFFF_FFFF,  32'h0,         1'b0};
        vecs[17] = '{32'h0200_4004, 4'hF, 32'hFFFF_FFFF,  32'h0,         1'b0};
        vecs[18] = '{32'h0200_4004, 4'h0, 32'h0,          32'hFFFF_FFFF, 1'b0};
        vecs[19] = '{32'h0200_0008, 4'h0, 32'h0,          32'h0,         1'b0};

        resetn = 1'b0;
        valid  = 1'b0;
        wstrb  = 4'h0;
        addr   = 32'h0;
        wdata  = 32'h0;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_ready", {31'h0, readyA}, 32'h0);
        checkOutput("rst_rdata", rdataA, 32'h0);
        checkOutput("rst_irq3", {31'h0, irq3A}, 32'h0);
        checkOutput("rst_irq7", {31'h0, irq7A}, 32'h0);
        resetn = 1'b1;
        applyStimulus(32'h0200_BFF8, 4'h0, 32'h0, 32'h0, 1'b0, rd);
        checkRange("rst_mtime_small", rd, 32'd0, 32'd2);

        $display("[TB] register map / strobe vectors");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i].addr, vecs[i].strb, vecs[i].wdata, vecs[i].exp, 1'b1, rd);
            checkOutput($sformatf("irq3_row%0d", i), {31'h0, irq3A}, {31'h0, vecs[i].expIrq3});
        end

        $display("[TB] timer compare");
        applyStimulus(32'h0200_BFF8, 4'hF, 32'h0,  32'h0, 1'b0, rd);
        applyStimulus(32'h0200_BFFC, 4'hF, 32'h0,  32'h0, 1'b0, rd);
        applyStimulus(32'h0200_4000, 4'hF, 32'd100, 32'h0, 1'b0, rd);
        applyStimulus(32'h0200_4004, 4'hF, 32'h0,  32'h0, 1'b0, rd);
        checkOutput("irq7_before", {31'h0, irq7A}, 32'h0);
        addr  = 32'h0200_BFF8;
        wstrb = 4'hF;
        wdata = 32'd90;
        valid = 1'b1;
        @(posedge clk);
        first = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            valid = 1'b0;
            wstrb = 4'h0;
            if (irq7A && first < 0) first = k;
        end
        checkOutput("irq7_rise_cycles", first, 32'd11);

        addr  = 32'h0200_4000;
        wstrb = 4'hF;
        wdata = 32'hFFFF_FFFF;
        valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("irq7_hold_ack", {31'h0, irq7A}, 32'h1);
        valid = 1'b0;
        wstrb = 4'h0;
        @(negedge clk);
        checkOutput("irq7_fall", {31'h0, irq7A}, 32'h0);

        $display("[TB] valid held across ready");
        addr  = 32'h0200_4004;
        wstrb = 4'h0;
        valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("held_ack1", {31'h0, readyA}, 32'h1);
        @(negedge clk);
        checkOutput("held_gap", {31'h0, readyA}, 32'h0);
        @(negedge clk);
        checkOutput("held_ack2", {31'h0, readyA}, 32'h1);
        valid = 1'b0;
        @(negedge clk);

        $display("[TB] out of window");
        addr  = 32'h0201_0000;
        wstrb = 4'hF;
        wdata = 32'h1;
        valid = 1'b1;
        seen  = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (readyA || readyB) seen++;
        end
        valid = 1'b0;
        wstrb = 4'h0;
        checkOutput("oow_no_ready", seen, 32'd0);
        checkOutput("oow_irq3", {31'h0, irq3A}, 32'h0);
        applyStimulus(32'h0200_0000, 4'h0, 32'h0, 32'h0, 1'b1, rd);

        $display("[TB] prescaled mtime");
        applyStimulus(32'h0300_BFF8, 4'hF, 32'h0, 32'h0, 1'b0, rd);
        applyStimulus(32'h0300_BFFC, 4'hF, 32'h0, 32'h0, 1'b0, rd);
        repeat (37) @(negedge clk);
        applyStimulus(32'h0300_BFF8, 4'h0, 32'h0, 32'h0, 1'b0, rd);
        checkRange("div4_count", rd, 32'd9, 32'd11);
        applyStimulus(32'h0300_BFFC, 4'hF, 32'h5,         32'h0, 1'b0, rd);
        applyStimulus(32'h0300_BFF8, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b0, rd);
        repeat (8) @(negedge clk);
        applyStimulus(32'h0300_BFFC, 4'h0, 32'h0, 32'h6, 1'b1, rd);
        applyStimulus(32'h0300_BFF8, 4'h0, 32'h0, 32'h0, 1'b0, rd);
        checkRange("carry_lo", rd, 32'd0, 32'd5);

        $display("[TB] reset mid transaction");
        applyStimulus(32'h0200_0000, 4'h1, 32'h1, 32'h0, 1'b0, rd);
        checkOutput("pre_rst_irq3", {31'h0, irq3A}, 32'h1);
        applyStimulus(32'h0200_0000, 4'h0, 32'h0, 32'h1, 1'b1, rd);
        addr  = 32'h0200_4000;
        wstrb = 4'hF;
        wdata = 32'h1111_1111;
        valid = 1'b1;
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        checkOutput("midrst_ready", {31'h0, readyA}, 32'h0);
        checkOutput("midrst_rdata", rdataA, 32'h0);
        checkOutput("midrst_irq3", {31'h0, irq3A}, 32'h0);
        checkOutput("midrst_irq7", {31'h0, irq7A}, 32'h0);
        @(negedge clk);
        valid = 1'b0;
        wstrb = 4'h0;
        @(negedge clk);
        resetn = 1'b1;
        applyStimulus(32'h0200_4000, 4'h0, 32'h0, 32'hFFFF_FFFF, 1'b1, rd);
        applyStimulus(32'h0200_4004, 4'h0, 32'h0, 32'hFFFF_FFFF, 1'b1, rd);
        applyStimulus(32'h0200_0000, 4'h0, 32'h0, 32'h0,         1'b1, rd);
        applyStimulus(32'h0300_BFFC, 4'h0, 32'h0, 32'h0,         1'b1, rd);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
